// File: rtl/rt_intv_tmr_pkg.sv
// Shared types for the interval timer.
// State encoding and mode constants.
package rt_intv_tmr_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/rt_bin_cnt.sv
// Loadable up/down binary counter.
// Priority: clear > load > count.
module rt_bin_cnt #(
  parameter int PARAM_BIT_NUM = 8
) (
  input  logic                     rt_i_clk,
  input  logic                     rt_i_rst,
  input  logic                     rt_i_set,
  input  logic                     rt_i_ce,
  input  logic                     rt_i_inc_n,
  input  logic [PARAM_BIT_NUM-1:0] rt_i_val,
  output logic [PARAM_BIT_NUM-1:0] rt_o_cnt,
  output logic                     rt_o_eqnz
);

  logic [PARAM_BIT_NUM-1:0] cnt;

  always_ff @(posedge rt_i_clk) begin
    if (rt_i_rst) begin
      cnt <= '0;
    end else if (rt_i_set) begin
      cnt <= rt_i_val;
    end else if (rt_i_ce) begin
      cnt <= rt_i_inc_n ? cnt - 1'b1 : cnt + 1'b1;
    end
  end

  assign rt_o_cnt  = cnt;
  assign rt_o_eqnz = |cnt;

endmodule

// File: rtl/rt_intv_tmr.sv
// Interval timer: one-shot / periodic control around rt_bin_cnt.
// Emits registered expire/err pulses and a saturating expiry count.
module rt_intv_tmr
  import rt_intv_tmr_pkg::*;
#(
  parameter int PARAM_BIT_NUM  = 8,
  parameter int PARAM_EXP_BITS = 8
) (
  input  logic                      rt_i_clk,
  input  logic                      rt_i_rst,
  input  logic                      rt_i_start,
  input  logic                      rt_i_stop,
  input  logic                      rt_i_mode,
  input  logic [PARAM_BIT_NUM-1:0]  rt_i_prd,
  input  logic                      rt_i_tick_ce,
  output logic                      rt_o_busy,
  output logic                      rt_o_expire,
  output logic                      rt_o_err,
  output logic [PARAM_BIT_NUM-1:0]  rt_o_cnt,
  output logic [PARAM_EXP_BITS-1:0] rt_o_exp_cnt
);

  state_t state, state_n;

  logic [PARAM_BIT_NUM-1:0]  shadow_prd;
  logic                      shadow_mode;
  logic [PARAM_EXP_BITS-1:0] exp_cnt;
  logic                      expire, err;

  logic [PARAM_BIT_NUM-1:0] cnt, cnt_val;
  logic cnt_eqnz, cnt_set, cnt_clr, cnt_ce;
  logic run, last, prd_zero;
  logic do_stop, do_start, do_fin;
  logic ld, xinc, xclr, expire_n, err_n;

  assign run      = (state == ST_RUN);
  assign prd_zero = (rt_i_prd == '0);
  // cnt==1: nonzero with every bit above the LSB clear
  assign last     = cnt_eqnz & ~|cnt[PARAM_BIT_NUM-1:1];

  assign do_stop  = rt_i_stop;
  assign do_start = rt_i_start & ~rt_i_stop;
  assign do_fin   = run & rt_i_tick_ce & last
                  & ~rt_i_stop & ~rt_i_start;

  assign cnt_ce = run & rt_i_tick_ce & cnt_eqnz & ~last;

  always_comb begin
    state_n  = state;
    cnt_set  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_val  = rt_i_prd;
    ld       = 1'b0;
    xinc     = 1'b0;
    xclr     = 1'b0;
    expire_n = 1'b0;
    err_n    = 1'b0;
    unique case (1'b1)
      do_stop: begin
        if (run) begin
          cnt_clr = 1'b1;
          state_n = ST_IDLE;
        end
      end
      do_start: begin
        if (prd_zero) begin
          err_n = 1'b1;
          if (run) begin
            cnt_clr = 1'b1;
            state_n = ST_IDLE;
          end
        end else begin
          cnt_set = 1'b1;
          ld      = 1'b1;
          xclr    = 1'b1;
          state_n = ST_RUN;
        end
      end
      do_fin: begin
        expire_n = 1'b1;
        xinc     = 1'b1;
        if (shadow_mode == MODE_PERIODIC) begin
          cnt_set = 1'b1;
          cnt_val = shadow_prd;
        end else begin
          cnt_clr = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rt_i_clk) begin
    if (rt_i_rst) begin
      state       <= ST_IDLE;
      shadow_prd  <= '0;
      shadow_mode <= MODE_ONESHOT;
      exp_cnt     <= '0;
      expire      <= 1'b0;
      err         <= 1'b0;
    end else begin
      state  <= state_n;
      expire <= expire_n;
      err    <= err_n;
      if (ld) begin
        shadow_prd  <= rt_i_prd;
        shadow_mode <= rt_i_mode;
      end
      if (xclr) begin
        exp_cnt <= '0;
      end else if (xinc && !(&exp_cnt)) begin
        exp_cnt <= exp_cnt + 1'b1;
      end
    end
  end

  rt_bin_cnt #(
    .PARAM_BIT_NUM(PARAM_BIT_NUM)
  ) u_cnt (
    .rt_i_clk   (rt_i_clk),
    .rt_i_rst   (rt_i_rst | cnt_clr),
    .rt_i_set   (cnt_set),
    .rt_i_ce    (cnt_ce),
    .rt_i_inc_n (1'b1),
    .rt_i_val   (cnt_val),
    .rt_o_cnt   (cnt),
    .rt_o_eqnz  (cnt_eqnz)
  );

  assign rt_o_busy    = run;
  assign rt_o_expire  = expire;
  assign rt_o_err     = err;
  assign rt_o_cnt     = cnt;
  assign rt_o_exp_cnt = exp_cnt;

endmodule

// File: tb/tb_rt_intv_tmr.sv
// Bench for rt_intv_tmr: directed scenarios plus random traffic,
// all cycles compared against a behavioural timer model.
module tb_rt_intv_tmr;

  localparam int N = 4;
  localparam int X = 3;
  localparam int XMAX = (1 << X) - 1;

  logic         clk = 1'b0;
  logic         rst, start, stop, mode, tick;
  logic [N-1:0] prd;
  logic         busy, expire, err;
  logic [N-1:0] cnt;
  logic [X-1:0] xc;

  int checks = 0;
  int failures = 0;

  int m_run, m_cnt, m_prd, m_mode, m_xc, e_exp, e_err;

  always #5 clk = ~clk;

  rt_intv_tmr #(
    .PARAM_BIT_NUM (N),
    .PARAM_EXP_BITS(X)
  ) dut (
    .rt_i_clk    (clk),
    .rt_i_rst    (rst),
    .rt_i_start  (start),
    .rt_i_stop   (stop),
    .rt_i_mode   (mode),
    .rt_i_prd    (prd),
    .rt_i_tick_ce(tick),
    .rt_o_busy   (busy),
    .rt_o_expire (expire),
    .rt_o_err    (err),
    .rt_o_cnt    (cnt),
    .rt_o_exp_cnt(xc)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Timer behaviour from its rules, applied to inputs seen at the edge.
  task automatic model_step();
    e_exp = 0;
    e_err = 0;
    if (rst) begin
      m_run = 0; m_cnt = 0; m_xc = 0;
    end else if (stop) begin
      if (m_run != 0) begin m_run = 0; m_cnt = 0; end
    end else if (start) begin
      if (prd == 0) begin
        e_err = 1;
        if (m_run != 0) begin m_run = 0; m_cnt = 0; end
      end else begin
        m_run = 1; m_cnt = int'(prd); m_prd = int'(prd);
        m_mode = int'(mode); m_xc = 0;
      end
    end else if (m_run != 0 && tick) begin
      if (m_cnt > 1) begin
        m_cnt = m_cnt - 1;
      end else begin
        e_exp = 1;
        if (m_xc < XMAX) m_xc = m_xc + 1;
        if (m_mode != 0) m_cnt = m_prd;
        else begin m_cnt = 0; m_run = 0; end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("busy", int'(busy), m_run);
    chk("expire", int'(expire), e_exp);
    chk("err", int'(err), e_err);
    chk("cnt", int'(cnt), m_cnt);
    chk("exp_cnt", int'(xc), m_xc);
  endtask

  task automatic idle_in();
    rst = 0; start = 0; stop = 0; tick = 0;
  endtask

  initial begin
    int n_exp;
    int guard;
    m_run = 0; m_cnt = 0; m_prd = 0; m_mode = 0; m_xc = 0;
    rst = 1; start = 0; stop = 0; mode = 0; tick = 0; prd = '0;
    cyc();
    cyc();
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt", int'(cnt), 0);

    // one-shot prd=3
    idle_in();
    mode = 0; prd = 4'd3; tick = 1; start = 1;
    cyc();
    chk("os_t1_cnt", int'(cnt), 3);
    start = 0;
    cyc();
    cyc();
    chk("os_t3_cnt", int'(cnt), 1);
    cyc();
    chk("os_expire", int'(expire), 1);
    chk("os_busy", int'(busy), 0);
    chk("os_xc", int'(xc), 1);

    // periodic prd=4, expire at t+5,9,13,17
    idle_in();
    mode = 1; prd = 4'd4; tick = 1; start = 1;
    cyc();
    start = 0;
    n_exp = 0;
    for (int i = 2; i <= 17; i++) begin
      cyc();
      if (expire) n_exp++;
    end
    chk("per_nexp", n_exp, 4);
    chk("per_xc", int'(xc), 4);
    chk("per_busy", int'(busy), 1);

    // retrigger at cnt=2 with prd=7
    idle_in();
    mode = 1; prd = 4'd5; tick = 1; start = 1;
    cyc();
    start = 0;
    prd = 4'd9;
    cyc(); cyc(); cyc();
    chk("rt_cnt2", int'(cnt), 2);
    start = 1; prd = 4'd7;
    cyc();
    start = 0;
    chk("rt_cnt", int'(cnt), 7);
    chk("rt_xc", int'(xc), 0);
    chk("rt_expire", int'(expire), 0);

    // stop coincident with final tick
    guard = 0;
    while (cnt != 1 && guard < 20) begin
      cyc();
      guard++;
    end
    chk("sv_reach1", int'(cnt), 1);
    stop = 1;
    cyc();
    stop = 0;
    chk("sv_busy", int'(busy), 0);
    chk("sv_cnt", int'(cnt), 0);
    chk("sv_expire", int'(expire), 0);

    // error from IDLE and from RUN
    idle_in();
    prd = '0; start = 1;
    cyc();
    chk("err_idle", int'(err), 1);
    chk("err_idle_busy", int'(busy), 0);
    start = 0;
    cyc();
    chk("err_pulse", int'(err), 0);
    prd = 4'd5; start = 1;
    cyc();
    prd = '0;
    cyc();
    chk("err_run", int'(err), 1);
    chk("err_run_busy", int'(busy), 0);
    start = 0;
    cyc();

    // saturation, then reset mid-run
    mode = 1; prd = 4'd1; tick = 1; start = 1;
    cyc();
    start = 0;
    for (int i = 0; i < 12; i++) cyc();
    chk("sat_xc", int'(xc), XMAX);
    chk("sat_expire", int'(expire), 1);
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_run_expire", int'(expire), 0);
    chk("rst_run_busy", int'(busy), 0);
    chk("rst_run_xc", int'(xc), 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 13) == 0);
      mode  = 1'($urandom_range(0, 1));
      tick  = ($urandom_range(0, 9) < 7);
      prd   = ($urandom_range(0, 9) == 0) ? '0
            : N'($urandom_range(1, (1 << N) - 1));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
